sobel_stream: RTL and testbench

Streaming successor to the frame-parallel Sobel stage. It accepts one grayscale pixel per handshake in raster order and produces one edge bit per pixel, with the same frame size and ordering. Two internal line buffers replace the full-frame input vector. The block sits between the image source and the VGA frame store, with valid/ready handshakes on both sides so either neighbour can stall it.

---
 rtl/sobel_stream.sv | 159 +++++++++++++++
 tb/tb_sobel_stream.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: one pixel in, one edge bit out, raster order.
// Optional build macro SOBEL_MAG_OUT_EN adds the registered gradient magnitude output out_mag.
module sobel_stream #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 128,
    parameter int PIX_W = 8
) (
    input  logic             ClkPort,
    input  logic             Reset,
    input  logic [PIX_W-1:0] threshold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_edge,
    output logic             out_first,
    output logic             out_last
`ifdef SOBEL_MAG_OUT_EN
    ,
    output logic [PIX_W+2:0] out_mag
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(DEPTH);
    localparam int GW = PIX_W + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    in_col, c_col;
    logic [RW-1:0]    in_row, c_row;
    logic [PIX_W-1:0] thr_q;

    logic [PIX_W-1:0] line0 [WIDTH];
    logic [PIX_W-1:0] line1 [WIDTH];
    // Left and centre window columns; the right column is the live line-buffer/input column.
    logic [PIX_W-1:0] win [3][2];

    logic [PIX_W-1:0]        top_px, mid_px;
    logic signed [GW-1:0]    gx_p0, gy_p0;
    logic [GW-1:0]           mag_p0;
    logic                    border, edge_p0;
    logic                    accept, slot_free, in_last, load, flush_done;

    function automatic logic signed [GW-1:0] grad(input logic [PIX_W-1:0] a, b, c, d, e, f);
        logic signed [GW-1:0] pos, neg;
        pos = $signed(GW'(a)) + $signed(GW'({b, 1'b0})) + $signed(GW'(c));
        neg = $signed(GW'(d)) + $signed(GW'({e, 1'b0})) + $signed(GW'(f));
        return pos - neg;
    endfunction

    function automatic logic [GW-1:0] abs_sum(input logic signed [GW-1:0] x, y);
        logic [GW-1:0] ax, ay;
        ax = x[GW-1] ? $unsigned(-x) : $unsigned(x);
        ay = y[GW-1] ? $unsigned(-y) : $unsigned(y);
        return ax + ay;
    endfunction

    // Stage p0: combinational window and gradients for the pixel being accepted
    assign top_px  = line1[in_col];
    assign mid_px  = line0[in_col];
    assign gx_p0   = grad(top_px, mid_px, in_pixel, win[0][0], win[1][0], win[2][0]);
    assign gy_p0   = grad(win[2][0], win[2][1], in_pixel, win[0][0], win[0][1], top_px);
    assign mag_p0  = abs_sum(gx_p0, gy_p0);
    assign border  = (c_row == '0) || (c_row == ROW_LAST) || (c_col == '0) || (c_col == COL_LAST);
    assign edge_p0 = !border && (mag_p0 > GW'(thr_q));

    assign slot_free  = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign in_last    = (in_row == ROW_LAST) && (in_col == COL_LAST);
    assign flush_done = (state == S_FLUSH) && out_valid && out_last && out_ready;
    assign load       = ((state == S_RUN) && accept) ||
                        ((state == S_FLUSH) && slot_free && !(out_valid && out_last));

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_FILL:  in_ready = 1'b1;
            S_RUN:   in_ready = slot_free;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge ClkPort) begin
        if (accept) begin
            line0[in_col] <= in_pixel;
            line1[in_col] <= mid_px;
            for (int r = 0; r < 3; r++) win[r][0] <= win[r][1];
            win[0][1] <= top_px;
            win[1][1] <= mid_px;
            win[2][1] <= in_pixel;
        end
    end

    // Stage p1: control state and the one-deep output register
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state     <= S_FILL;
            in_col    <= '0;
            in_row    <= '0;
            c_col     <= '0;
            c_row     <= '0;
            thr_q     <= '0;
            out_valid <= 1'b0;
            out_edge  <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (state == S_FILL && in_row == '0 && in_col == '0) thr_q <= threshold;
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end

            case (state)
                S_FILL:  if (accept && in_row == RW'(1) && in_col == '0) state <= S_RUN;
                S_RUN:   if (accept && in_last) state <= S_FLUSH;
                S_FLUSH: if (flush_done) state <= S_FILL;
                default: state <= S_FILL;
            endcase

            if (load) begin
                out_valid <= 1'b1;
                out_edge  <= edge_p0;
                out_first <= (c_row == '0) && (c_col == '0);
                out_last  <= (c_row == ROW_LAST) && (c_col == COL_LAST);
                if (c_col == COL_LAST) begin
                    c_col <= '0;
                    c_row <= (c_row == ROW_LAST) ? '0 : c_row + 1'b1;
                end else begin
                    c_col <= c_col + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SOBEL_MAG_OUT_EN
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            out_mag <= '0;
        end else if (load) begin
            out_mag <= border ? '0 : mag_p0;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on a reduced frame size, with a per-pixel Sobel reference model.
// Checks out_mag as well when SOBEL_MAG_OUT_EN is defined.
module tb_sobel_stream;

    localparam int W  = 16;
    localparam int D  = 10;
    localparam int N  = W * D;
    localparam int PW = 8;

    typedef struct packed {
        logic          e;
        logic          f;
        logic          l;
        logic [PW+2:0] m;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [PW-1:0] threshold;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic          out_edge;
    logic          out_first;
    logic          out_last;
`ifdef SOBEL_MAG_OUT_EN
    logic [PW+2:0] out_mag;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [PW-1:0] img [N];

    sobel_stream #(.WIDTH(W), .DEPTH(D), .PIX_W(PW)) dut (
        .ClkPort   (clk),
        .Reset     (rst),
        .threshold (threshold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_edge  (out_edge),
        .out_first (out_first),
        .out_last  (out_last)
`ifdef SOBEL_MAG_OUT_EN
        ,
        .out_mag   (out_mag)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int px(input int r, input int c);
        return int'(img[r * W + c]);
    endfunction

    // Reference: straight Sobel on the stored image, borders forced to zero.
    task automatic push_expected(input logic [PW-1:0] thr);
        for (int j = 0; j < N; j++) begin
            int r, c, gx, gy, mag;
            exp_t x;
            r = j / W;
            c = j % W;
            mag = 0;
            if (r > 0 && r < D - 1 && c > 0 && c < W - 1) begin
                gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
                   - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
                gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
                   - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
                mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            end
            x.e = (mag > int'(thr));
            x.f = (j == 0);
            x.l = (j == N - 1);
            x.m = (PW+3)'(mag);
            exp_q.push_back(x);
        end
    endtask

    // pat 0: constant v; 1: left half 0, right half v; 2: random masked by v
    task automatic fill(input int pat, input int v);
        for (int i = 0; i < N; i++) begin
            case (pat)
                0:       img[i] = PW'(v);
                1:       img[i] = ((i % W) >= W / 2) ? PW'(v) : '0;
                default: img[i] = PW'($urandom) & PW'(v);
            endcase
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_frame(input logic [PW-1:0] thr, input int vpct, input int rpct, input int stop_after);
        int idx = 0;
        int budget = 0;
        push_expected(thr);
        while (idx < stop_after && budget < 20000) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(99) < vpct);
            in_pixel  = img[idx];
            threshold = (idx == 0) ? thr : PW'($urandom_range(255));
            out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            budget++;
        end
        check("input_budget", idx, stop_after);
    endtask

    task automatic drain(input int rpct, input int exp_count);
        int budget = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && budget < 20000) begin
            out_ready = ($urandom_range(99) < rpct);
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_left", exp_q.size(), 0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("output_count", n_out, exp_count);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_vec++;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got edge=%0b first=%0b last=%0b, expected no output",
                             out_edge, out_first, out_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({out_edge, out_first, out_last} !== {mon_e.e, mon_e.f, mon_e.l}) begin
                        n_err++;
                        $display("FAIL out_bits[%0d]: got edge/first/last=%b%b%b, expected %b%b%b",
                                 n_out, out_edge, out_first, out_last, mon_e.e, mon_e.f, mon_e.l);
                    end
`ifdef SOBEL_MAG_OUT_EN
                    n_vec++;
                    if (out_mag !== mon_e.m) begin
                        n_err++;
                        $display("FAIL out_mag[%0d]: got %0d, expected %0d", n_out, out_mag, mon_e.m);
                    end
`endif
                end
                n_out++;
            end else if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_in_ready: got %b, expected 0", in_ready);
            end
        end
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = '0;
        threshold = '0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_edge", int'(out_edge), 0);
        check("rst_out_first", int'(out_first), 0);
        check("rst_out_last", int'(out_last), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        n_out = 0;
        fill(0, 8'h80); drive_frame(8'h33, 100, 100, N);
        fill(1, 8'hFF); drive_frame(8'h33, 100, 100, N);
        fill(1, 8'h01); drive_frame(8'h04, 100, 100, N);
        fill(1, 8'h01); drive_frame(8'h03, 100, 100, N);
        fill(2, 8'hFF); drive_frame(8'h60, 100, 100, N);
        drive_frame(8'h60, 50, 50, N);
        fill(2, 8'h0F); drive_frame(8'hFF, 100, 100, N);
        drain(100, 7 * N);

        // Abort a frame mid-way with an asynchronous reset.
        fill(2, 8'hFF); drive_frame(8'h40, 50, 50, 70);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        n_out = 0;
        fill(2, 8'hFF); drive_frame(8'h50, 50, 50, N);
        drain(60, N);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
